serial_adder: RTL

- Bit-serial adder built around the team's existing single-bit Fulladder cell (ports a, b, c, sum, carry).
- Latches two WIDTH-bit operands, presents them LSB-first to the Fulladder one bit per clock, and holds the carry in a flip-flop between bits.
- Assembles the sum and reports completion with a start/busy/done handshake.
- Sits directly upstream of Fulladder as its sequencing stage: the area-cheap alternative to a WIDTH-wide ripple adder.

---
 rtl/serial_adder_pkg.sv | 9 +
 rtl/serial_adder_fa.sv | 11 +
 rtl/serial_adder.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared FSM state encoding for the bit-serial adder.
// Only IDLE/RUN/DONE are legal; the fourth code is treated as a fault and recovers to IDLE.
package serial_adder_pkg;
    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell used as the serial datapath bit-slice.
module Fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: feeds latched operands LSB-first through one full adder,
// keeping the carry in a flop, and publishes {cout,sum_out} with a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_res_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    Fulladder u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c     (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    // The result register holds only the upper WIDTH-1 bits; the newest bit enters at the MSB.
    assign w_res_next = {w_fa_sum, r_res_sh};
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:  w_next_state = start  ? S_RUN  : S_IDLE;
            S_RUN:   w_next_state = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next_state = start  ? S_RUN  : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand load, serial shifting, carry flop and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= {CW{1'b0}};
            r_a_sh   <= {WIDTH{1'b0}};
            r_b_sh   <= {WIDTH{1'b0}};
            r_res_sh <= {(WIDTH-1){1'b0}};
            r_carry  <= 1'b0;
            r_sum    <= {WIDTH{1'b0}};
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= {CW{1'b0}};
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin;
        end else if (r_state == S_RUN) begin
            r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res_sh <= w_res_next[WIDTH-1:1];
            r_carry  <= w_fa_carry;
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_fa_carry;
            end else begin
                r_sum  <= r_sum;
                r_cout <= r_cout;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign sum_out = r_sum;
    assign cout    = r_cout;
endmodule
